// File: rtl/fma_issue_arbiter_pkg.sv
// Shared types and helpers for the fpFMA issue arbiter and its requester-ID FIFO.
package fma_issue_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_FPWID = 80;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        WAIT
    } state_t;

    typedef logic [$clog2(DEF_NREQ)-1:0] rid_t;

    // Operands carry four extra bits beyond the FP format width.
    function automatic int op_width(input int fpwid);
        return fpwid + 4;
    endfunction

endpackage

// File: rtl/fma_id_fifo.sv
// In-order FIFO of requester IDs for ops in flight in the FMA pipeline.
module fma_id_fifo
    import fma_issue_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A pop on an empty FIFO is refused; a push into a full FIFO only lands if a pop frees the slot.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign dout  = r_mem[r_rp];
    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Round-robin arbiter sharing one fpFMA unit among NREQ requesters; queued requester
// IDs route the unit's in-order result strobes back as one-cycle done pulses.
module fma_issue_arbiter
    import fma_issue_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int FPWID  = DEF_FPWID,
    parameter int TAGW   = 6,
    parameter int MAXOUT = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ce,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ*40-1:0]               req_instr,
    input  logic [NREQ*3-1:0]                req_rm,
    input  logic [NREQ*op_width(FPWID)-1:0]  req_a,
    input  logic [NREQ*op_width(FPWID)-1:0]  req_b,
    input  logic [NREQ*op_width(FPWID)-1:0]  req_c,
    input  logic [NREQ*TAGW-1:0]             req_tag,
    output logic [NREQ-1:0]                  gnt,
    output logic                             fma_ld,
    output logic [39:0]                      fma_instr,
    output logic [2:0]                       fma_rm,
    output logic [op_width(FPWID)-1:0]       fma_a,
    output logic [op_width(FPWID)-1:0]       fma_b,
    output logic [op_width(FPWID)-1:0]       fma_c,
    output logic [TAGW-1:0]                  fma_tag,
    output logic                             fma_v,
    input  logic                             fma_idle,
    input  logic                             fma_vo,
    output logic [NREQ-1:0]                  done,
    output logic [$clog2(MAXOUT):0]          outstanding,
    output logic                             err
);
    localparam int OW  = op_width(FPWID);
    localparam int IDW = $clog2(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [IDW-1:0]    r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic              r_ld;
    logic [39:0]       r_instr;
    logic [2:0]        r_rm;
    logic [OW-1:0]     r_a;
    logic [OW-1:0]     r_b;
    logic [OW-1:0]     r_c;
    logic [TAGW-1:0]   r_tag;
    logic [NREQ-1:0]   r_done;
    logic              r_err;

    logic [IDW-1:0]    w_sel;
    logic [IDW-1:0]    w_cand;
    logic [IDW-1:0]    w_head;
    logic              w_found;
    logic              w_issue;
    logic              w_full;
    logic              w_empty;
    logic [$clog2(MAXOUT):0] w_count;
    int unsigned       w_idx;

    // Scan from the pointer, wrapping modulo NREQ, so non-power-of-2 NREQ stays in range.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx  = (32'(r_ptr) + i) % NREQ;
            w_cand = IDW'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Credit check uses the registered count, so a same-cycle pop never unblocks a full FIFO.
    assign w_issue = (r_state == IDLE) && ce && fma_idle && w_found && !w_full;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_issue)         w_next = LOADED;
            LOADED:  if (ce)              w_next = WAIT;
            WAIT:    if (ce && fma_idle)  w_next = IDLE;
            default:                      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_ld    <= 1'b0;
            r_instr <= '0;
            r_rm    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_tag   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ld  <= w_issue;
            r_gnt <= w_issue ? (NREQ'(1) << w_sel) : '0;
            if (w_issue) begin
                r_ptr   <= (w_sel == IDW'(NREQ-1)) ? '0 : w_sel + 1'b1;
                r_instr <= req_instr[w_sel*40 +: 40];
                r_rm    <= req_rm[w_sel*3 +: 3];
                r_a     <= req_a[w_sel*OW +: OW];
                r_b     <= req_b[w_sel*OW +: OW];
                r_c     <= req_c[w_sel*OW +: OW];
                r_tag   <= req_tag[w_sel*TAGW +: TAGW];
            end
            r_done <= (fma_vo && !w_empty) ? (NREQ'(1) << w_head) : '0;
            if (fma_vo && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    fma_id_fifo #(
        .DEPTH (MAXOUT),
        .W     (IDW)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_issue),
        .pop   (fma_vo),
        .din   (w_sel),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign gnt         = r_gnt;
    assign fma_ld      = r_ld;
    assign fma_v       = r_ld;
    assign fma_instr   = r_instr;
    assign fma_rm      = r_rm;
    assign fma_a       = r_a;
    assign fma_b       = r_b;
    assign fma_c       = r_c;
    assign fma_tag     = r_tag;
    assign done        = r_done;
    assign outstanding = w_count;
    assign err         = r_err;

endmodule
